// File: rtl/vec_exec_unit_if.sv
// Handshake and operand/result bundle between the CPU controller and vec_exec_unit.
// master = controller side, slave = execution unit side.
interface vec_exec_unit_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned VLEN   = 16
) ();
    logic                   start;
    logic [1:0]             op;
    logic [VLEN*DATA_W-1:0] a_vec;
    logic [VLEN*DATA_W-1:0] b_vec;
    logic                   ready;
    logic                   done;
    logic [VLEN*DATA_W-1:0] res_lo;
    logic [VLEN*DATA_W-1:0] res_hi;

    modport master (
        output start, op, a_vec, b_vec,
        input  ready, done, res_lo, res_hi
    );

    modport slave (
        input  start, op, a_vec, b_vec,
        output ready, done, res_lo, res_hi
    );
endinterface

// File: rtl/vec_exec_unit.sv
// Vector execution unit: ADD/SUB/MUL/DOT on VLEN signed elements, LANES per cycle,
// double-width results split into low/high vectors, start/ready/done handshake.
module vec_exec_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned VLEN   = 16,
    parameter int unsigned LANES  = 4
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    vec_exec_unit_if.slave io_bus
);
    localparam int unsigned N  = VLEN / LANES;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned IW = (VLEN > 1) ? $clog2(VLEN) : 1;
    localparam int unsigned W2 = 2 * DATA_W;

    if ((VLEN % LANES) != 0) begin : g_bad_lanes
        $fatal(1, "vec_exec_unit: VLEN must be a multiple of LANES");
    end

    typedef enum logic [0:0] {StIdle, StRun} state_e;
    typedef enum logic [1:0] {OpAdd = 2'b00, OpSub = 2'b01, OpMul = 2'b10, OpDot = 2'b11} op_e;

    state_e              r_state;
    op_e                 r_op;
    logic [KW-1:0]       r_k;
    logic                r_done;
    logic [W2-1:0]       r_acc;
    logic [DATA_W-1:0]   r_a      [VLEN];
    logic [DATA_W-1:0]   r_b      [VLEN];
    logic [DATA_W-1:0]   r_res_lo [VLEN];
    logic [DATA_W-1:0]   r_res_hi [VLEN];

    logic [DATA_W-1:0]   w_a_in   [VLEN];
    logic [DATA_W-1:0]   w_b_in   [VLEN];
    logic [IW-1:0]       w_idx    [LANES];
    logic signed [W2-1:0] w_a_ext  [LANES];
    logic signed [W2-1:0] w_b_ext  [LANES];
    logic signed [W2-1:0] w_prod   [LANES];
    logic signed [W2-1:0] w_lane_r [LANES];
    logic signed [W2-1:0] w_dot;
    logic [W2-1:0]       w_acc_d;

    for (genvar i = 0; i < VLEN; i++) begin : g_pack
        assign w_a_in[i] = io_bus.a_vec[i*DATA_W +: DATA_W];
        assign w_b_in[i] = io_bus.b_vec[i*DATA_W +: DATA_W];
        assign io_bus.res_lo[i*DATA_W +: DATA_W] = r_res_lo[i];
        assign io_bus.res_hi[i*DATA_W +: DATA_W] = r_res_hi[i];
    end

    // Each lane works on element k*LANES+l of the captured operands.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_idx[l]    = IW'(32'(r_k) * LANES + l);
        assign w_a_ext[l]  = W2'($signed(r_a[w_idx[l]]));
        assign w_b_ext[l]  = W2'($signed(r_b[w_idx[l]]));
        assign w_prod[l]   = w_a_ext[l] * w_b_ext[l];
        assign w_lane_r[l] = (r_op == OpAdd) ? (w_a_ext[l] + w_b_ext[l]) :
                             (r_op == OpSub) ? (w_a_ext[l] - w_b_ext[l]) : w_prod[l];
    end

    always_comb begin
        w_dot = '0;
        for (int j = 0; j < LANES; j++) begin
            w_dot = w_dot + w_prod[j];
        end
        w_acc_d = r_acc + w_dot;
    end

    assign io_bus.ready = (r_state == StIdle);
    assign io_bus.done  = r_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_op     <= OpAdd;
            r_k      <= '0;
            r_done   <= 1'b0;
            r_acc    <= '0;
            r_a      <= '{default: '0};
            r_b      <= '{default: '0};
            r_res_lo <= '{default: '0};
            r_res_hi <= '{default: '0};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (io_bus.start) begin
                        r_a      <= w_a_in;
                        r_b      <= w_b_in;
                        r_op     <= op_e'(io_bus.op);
                        r_acc    <= '0;
                        r_res_lo <= '{default: '0};
                        r_res_hi <= '{default: '0};
                        r_k      <= '0;
                        r_state  <= StRun;
                    end
                end
                StRun: begin
                    if (r_op == OpDot) begin
                        r_acc       <= w_acc_d;
                        r_res_lo[0] <= w_acc_d[DATA_W-1:0];
                        r_res_hi[0] <= w_acc_d[W2-1:DATA_W];
                    end else begin
                        for (int j = 0; j < LANES; j++) begin
                            r_res_lo[w_idx[j]] <= w_lane_r[j][DATA_W-1:0];
                            r_res_hi[w_idx[j]] <= w_lane_r[j][W2-1:DATA_W];
                        end
                    end
                    if (r_k == KW'(N - 1)) begin
                        r_state <= StIdle;
                        r_done  <= 1'b1;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end
endmodule
